// File: rtl/ch_arb_pkg.sv
// Shared types and helpers for the ch_queue arbiter: FSM state encoding,
// width calculation and the wrap-around index increment.
package ch_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < value) r = i + 1;
    end
    return r;
  endfunction

  // Explicit compare instead of modulo so non-power-of-two N wraps correctly
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ch_queue_arbiter_if.sv
// Producer-side and enqueue-side signals of the ch_queue arbiter.
// master is the arbiter's view, slave is the surrounding subsystem's view.
interface ch_queue_arbiter_if
  import ch_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
);

  localparam int GW = clog2(N);

  logic [N-1:0]   io_in_valid;
  logic [N*W-1:0] io_in_data;
  logic [N-1:0]   io_in_ready;
  logic           io_out_valid;
  logic [W-1:0]   io_out_data;
  logic [GW-1:0]  io_out_grant;
  logic           io_out_ready;
  logic           io_busy;

  modport master (
    input  io_in_valid,
    input  io_in_data,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_out_data,
    output io_out_grant,
    output io_busy
  );

  modport slave (
    output io_in_valid,
    output io_in_data,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_out_data,
    input  io_out_grant,
    input  io_busy
  );

endinterface

// File: rtl/ch_rr_pick.sv
// Rotating-priority find-first: returns the first set valid bit at or after
// prio, wrapping past N-1 back to 0.
module ch_rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [GW-1:0] prio,
  output logic [GW-1:0] win,
  output logic          any
);

  function automatic int rot(input int p, input int k);
    return (p + k >= N) ? p + k - N : p + k;
  endfunction

  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && valid[rot(int'(prio), k)]) begin
        any = 1'b1;
        win = GW'(rot(int'(prio), k));
      end
    end
  end

endmodule

// File: rtl/ch_queue_arbiter.sv
// N-way round-robin arbiter with burst hold feeding one ch_queue enqueue port
// through a single registered output stage.
module ch_queue_arbiter
  import ch_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 4,
  parameter int MAX_BURST = 2
) (
  input logic               clk,
  input logic               reset,
  ch_queue_arbiter_if.master bus
);

  localparam int GW = clog2(N);
  localparam int CW = clog2(MAX_BURST + 1);

  arb_state_t    state;
  logic [GW-1:0] prio;
  logic [GW-1:0] owner;
  logic [CW-1:0] burst_cnt;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [GW-1:0] out_grant;

  logic [GW-1:0] owner_nxt;
  logic [GW-1:0] pick_prio;
  logic [GW-1:0] pick_win;
  logic [GW-1:0] win;
  logic          any_valid;
  logic          burst_hold;
  logic          load_en;
  logic          accept;

  assign owner_nxt  = GW'(wrap_inc(int'(owner), N));
  assign burst_hold = (state == ARB_BURST) && bus.io_in_valid[owner];

  // A burst owner that dropped valid hands off in the same cycle, searching from owner+1
  assign pick_prio  = (state == ARB_BURST) ? owner_nxt : prio;

  ch_rr_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .valid (bus.io_in_valid),
    .prio  (pick_prio),
    .win   (pick_win),
    .any   (any_valid)
  );

  assign win     = burst_hold ? owner : pick_win;
  assign load_en = ~out_valid | bus.io_out_ready;
  assign accept  = load_en & any_valid;

  always_comb begin
    bus.io_in_ready = '0;
    if (accept && !reset) bus.io_in_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      prio      <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
    end else if (load_en) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= bus.io_in_data[int'(win)*W +: W];
        out_grant <= win;
      end else begin
        out_valid <= 1'b0;
      end

      if (burst_hold) begin
        if (burst_cnt + CW'(1) == CW'(MAX_BURST)) begin
          state     <= ARB_IDLE;
          prio      <= owner_nxt;
          burst_cnt <= '0;
        end else begin
          burst_cnt <= burst_cnt + CW'(1);
        end
      end else begin
        if (state == ARB_BURST) begin
          state     <= ARB_IDLE;
          prio      <= owner_nxt;
          burst_cnt <= '0;
        end
        // Later assignments below override the release defaults when a new winner is taken
        if (accept) begin
          if (MAX_BURST == 1) begin
            state <= ARB_IDLE;
            prio  <= GW'(wrap_inc(int'(win), N));
          end else begin
            state     <= ARB_BURST;
            owner     <= win;
            burst_cnt <= CW'(1);
          end
        end
      end
    end
  end

  assign bus.io_out_valid = out_valid;
  assign bus.io_out_data  = out_data;
  assign bus.io_out_grant = out_grant;
  assign bus.io_busy      = (state == ARB_BURST);

endmodule

// File: tb/tb_ch_queue_arbiter.sv
// Bench for ch_queue_arbiter: directed arbitration scenarios plus random traffic,
// all compared against a queue-level round-robin model kept in the bench.
module tb_ch_queue_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int MB = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ch_queue_arbiter_if #(.N(N), .W(W)) bus ();

  ch_queue_arbiter #(
    .N         (N),
    .W         (W),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int vecCount = 0;
  int errCount = 0;

  // Model: owner < 0 means nobody holds the port
  int mOwner;
  int mBeats;
  int mPrio;
  bit mValid;
  int mData;
  int mGrant;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mBeats = 0;
    mPrio  = 0;
    mValid = 1'b0;
    mData  = 0;
    mGrant = 0;
  endtask

  function automatic int modelWinner(input logic [N-1:0] v);
    int start;
    if (mOwner >= 0 && v[mOwner]) return mOwner;
    start = (mOwner >= 0) ? (mOwner + 1) % N : mPrio;
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Drives one cycle of inputs, checks everything visible before the edge, advances the model
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy);
    int  win;
    bit  load;
    bit  accept;
    logic [N-1:0] expReady;
    @(negedge clk);
    bus.io_in_valid  = v;
    bus.io_in_data   = d;
    bus.io_out_ready = rdy;
    #1;
    win      = modelWinner(v);
    load     = !mValid || rdy;
    accept   = load && (win >= 0);
    expReady = accept ? N'(1 << win) : '0;
    checkOutput("outValid", 32'(bus.io_out_valid), 32'(mValid));
    if (mValid) begin
      checkOutput("outData", 32'(bus.io_out_data), 32'(mData));
      checkOutput("outGrant", 32'(bus.io_out_grant), 32'(mGrant));
    end
    checkOutput("busy", 32'(bus.io_busy), 32'(mOwner >= 0));
    checkOutput("inReady", 32'(bus.io_in_ready), 32'(expReady));
    if (load) begin
      if (mOwner >= 0 && !v[mOwner]) begin
        mPrio  = (mOwner + 1) % N;
        mOwner = -1;
        mBeats = 0;
      end
      if (accept) begin
        mValid = 1'b1;
        mData  = int'(d[win*W +: W]);
        mGrant = win;
        if (mOwner >= 0) begin
          mBeats++;
          if (mBeats == MB) begin
            mPrio  = (mOwner + 1) % N;
            mOwner = -1;
            mBeats = 0;
          end
        end else if (MB == 1) begin
          mPrio = (win + 1) % N;
        end else begin
          mOwner = win;
          mBeats = 1;
        end
      end else begin
        mValid = 1'b0;
      end
    end
  endtask

  task automatic checkAfterEdge(input string tag, input logic [31:0] observed_sel, input logic [31:0] expected);
    checkOutput(tag, observed_sel, expected);
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.io_in_valid  = '1;
    bus.io_in_data   = 16'h4321;
    bus.io_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstValid", 32'(bus.io_out_valid), 32'd0);
    checkOutput("rstReady", 32'(bus.io_in_ready), 32'd0);
    checkOutput("rstBusy", 32'(bus.io_busy), 32'd0);
    checkOutput("rstGrant", 32'(bus.io_out_grant), 32'd0);
    checkOutput("rstData", 32'(bus.io_out_data), 32'd0);
    bus.io_in_valid  = '0;
    bus.io_out_ready = 1'b0;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    int seqGrant [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic [31:0] rnd;

    modelReset();
    bus.io_in_valid  = '0;
    bus.io_in_data   = '0;
    bus.io_out_ready = 1'b0;

    // Everyone requesting: pairs of beats rotate through the requesters
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'b1111, 16'h4321, 1'b1);
      @(posedge clk); #1;
      checkAfterEdge("seqGrant", 32'(bus.io_out_grant), 32'(seqGrant[k]));
      checkAfterEdge("seqData", 32'(bus.io_out_data), 32'(seqGrant[k] + 1));
    end

    // Lone requester keeps full throughput while busy toggles between bursts
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0100, 16'h0700 | 16'(k << 8), 1'b1);
      @(posedge clk); #1;
      checkAfterEdge("soloGrant", 32'(bus.io_out_grant), 32'd2);
      checkAfterEdge("soloBusy", 32'(bus.io_busy), 32'((k % 2) == 0));
    end

    // Downstream stall holds the output beat and blocks all requesters
    doReset();
    applyStimulus(4'b0001, 16'h000A, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1111, 16'h5555, 1'b0);
      checkOutput("stallData", 32'(bus.io_out_data), 32'hA);
    end
    applyStimulus(4'b1111, 16'h6789, 1'b1);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Burst owner drops valid: hand-off goes to the next valid requester
    doReset();
    applyStimulus(4'b0010, 16'h00B0, 1'b1);
    applyStimulus(4'b1000, 16'hC000, 1'b1);
    @(posedge clk); #1;
    checkAfterEdge("dropGrant", 32'(bus.io_out_grant), 32'd3);
    applyStimulus(4'b1000, 16'hD000, 1'b1);
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    @(posedge clk); #1;
    checkAfterEdge("wrapGrant", 32'(bus.io_out_grant), 32'd0);
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    // Reset in the middle of a burst drops the beat at once
    doReset();
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    @(posedge clk); #1;
    checkOutput("preRstBusy", 32'(bus.io_busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midRstValid", 32'(bus.io_out_valid), 32'd0);
    checkOutput("midRstReady", 32'(bus.io_in_ready), 32'd0);
    checkOutput("midRstBusy", 32'(bus.io_busy), 32'd0);
    bus.io_in_valid = '0;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    @(posedge clk); #1;
    checkAfterEdge("postRstGrant", 32'(bus.io_out_grant), 32'd0);

    // Random traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
      rnd = $urandom;
      v   = rnd[N-1:0];
      rnd = $urandom;
      d   = rnd[N*W-1:0];
      applyStimulus(v, d, ($urandom_range(0, 3) != 0));
    end
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
